// File: rtl/vga_pkg.sv
// Shared constants and the capture-state type for the scope sample path.
package vga_pkg;

  localparam int          N_SAMPLES_DEFAULT = 256;
  localparam logic [11:0] ADC_MID           = 12'd2047;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    READY
  } cap_state_t;

endpackage

// File: rtl/trigger_detect.sv
// Edge trigger on kept ADC samples: previous-sample register, level compare, polarity select.
module trigger_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        sample_en,
  input  logic [11:0] sample,
  input  logic [11:0] trig_level,
  input  logic        trig_falling,
  output logic        hit
);

  logic [11:0] prev;
  logic        prev_valid;
  logic        rise;
  logic        fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= 12'd0;
      prev_valid <= 1'b0;
    end else if (arm) begin
      prev_valid <= 1'b0;
    end else if (sample_en) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  assign rise = (prev < trig_level) && (sample >= trig_level);
  assign fall = (prev >= trig_level) && (sample < trig_level);

  // The first kept sample after arming only seeds prev.
  assign hit = sample_en && prev_valid && (trig_falling ? fall : rise);

endmodule

// File: rtl/sample_capture.sv
// Triggered, decimated ADC frame capture with vblank-synchronised publish to the display buffer.
// Optional auto-trigger timeout is enabled by defining CAPTURE_AUTO_TRIG_EN.
//
// state     | meaning
// IDLE      | display frozen, waiting for run
// WAIT_TRIG | armed, watching kept samples for the trigger edge
// CAPTURE   | filling the back buffer at wr_idx
// READY     | frame complete, waiting for a vblnk rising edge to publish
module sample_capture
  import vga_pkg::*;
#(
  parameter int N_SAMPLES    = N_SAMPLES_DEFAULT,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic [11:0] trig_level,
  input  logic        trig_falling,
  input  logic [3:0]  decim,
  input  logic        run,
  input  logic        vblnk,
  output logic [11:0] data_display [0:N_SAMPLES-1],
  output logic        frame_done,
  output logic        triggered
);

  localparam int IDX_W = $clog2(N_SAMPLES);

  cap_state_t       state;
  logic [3:0]       decim_lat;
  logic [3:0]       dec_cnt;
  logic [IDX_W-1:0] wr_idx;
  logic [11:0]      back_buf [0:N_SAMPLES-1];
  logic             vblnk_q;
  logic             frame_trig;

  logic sampling;
  logic kept;
  logic vblnk_rise;
  logic publish;
  logic arm;
  logic trig_hit;
  logic auto_hit;

  assign sampling   = (state == WAIT_TRIG) || (state == CAPTURE);
  assign kept       = sampling && adc_valid && (dec_cnt == 4'd0);
  assign vblnk_rise = vblnk && !vblnk_q;
  assign publish    = (state == READY) && vblnk_rise;
  assign arm        = ((state == IDLE) && run) || (publish && run);

  trigger_detect u_trigger_detect (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .sample_en    (kept && (state == WAIT_TRIG)),
    .sample       (adc_data),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .hit          (trig_hit)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      to_cnt <= '0;
    end else if ((state == WAIT_TRIG) && kept) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Fires on the kept sample that brings the count to AUTO_TIMEOUT.
  assign auto_hit = (state == WAIT_TRIG) && kept && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
`else
  assign auto_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      decim_lat  <= 4'd0;
      dec_cnt    <= 4'd0;
      wr_idx     <= '0;
      vblnk_q    <= 1'b0;
      frame_done <= 1'b0;
      triggered  <= 1'b0;
      frame_trig <= 1'b0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        back_buf[i]     <= ADC_MID;
        data_display[i] <= ADC_MID;
      end
    end else begin
      vblnk_q    <= vblnk;
      frame_done <= 1'b0;

      if (arm) begin
        decim_lat <= decim;
        dec_cnt   <= 4'd0;
      end else if (sampling && adc_valid) begin
        dec_cnt <= (dec_cnt == decim_lat) ? 4'd0 : dec_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (run) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig_hit || auto_hit) begin
            back_buf[0] <= adc_data;
            wr_idx      <= IDX_W'(1);
            frame_trig  <= trig_hit;
            state       <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (kept) begin
            back_buf[wr_idx] <= adc_data;
            if (wr_idx == IDX_W'(N_SAMPLES - 1)) state <= READY;
            else wr_idx <= wr_idx + IDX_W'(1);
          end
        end
        READY: begin
          if (vblnk_rise) begin
            for (int i = 0; i < N_SAMPLES; i++) data_display[i] <= back_buf[i];
            frame_done <= 1'b1;
            triggered  <= frame_trig;
            state      <= run ? WAIT_TRIG : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: table of trigger scenarios plus hand-written corner sequences.
module tb_sample_capture;

  localparam int NS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_data = 12'd0;
  logic        adc_valid = 1'b0;
  logic [11:0] trig_level = 12'd2048;
  logic        trig_falling = 1'b0;
  logic [3:0]  decim = 4'd0;
  logic        run = 1'b0;
  logic        vblnk = 1'b0;
  logic [11:0] disp [0:NS-1];
  logic        frame_done;
  logic        triggered;

  int checks = 0;
  int errors = 0;
  int fd_total = 0;

  sample_capture dut (
    .clk          (clk),
    .rst          (rst),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .decim        (decim),
    .run          (run),
    .vblnk        (vblnk),
    .data_display (disp),
    .frame_done   (frame_done),
    .triggered    (triggered)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_total++;

  typedef struct {
    int          wave;      // 0 = ramp step 16, 1 = square 3000/1000 period 16
    logic [11:0] level;
    logic        falling;
    logic [3:0]  decim;
    int          trig_i;    // stream index of the triggering sample
    int          exp0;
    int          exp_last;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [11:0] wave_val(input int wave, input int i);
    if (wave == 0) return 12'((i * 16) % 4096);
    return ((i % 16) < 8) ? 12'd3000 : 12'd1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; adc_valid = 1'b0; vblnk = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic stream(input int wave, input int n);
    for (int i = 0; i < n; i++) begin
      adc_data  = wave_val(wave, i);
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic stream_const(input logic [11:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      adc_data  = val;
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic pulse_vblnk();
    vblnk = 1'b1;
    tick();
    vblnk = 1'b0;
    repeat (10) tick();
  endtask

  function automatic int count_not(input logic [11:0] val);
    int bad = 0;
    for (int k = 0; k < NS; k++) if (disp[k] !== val) bad++;
    return bad;
  endfunction

  initial begin
    int fd_start;
    int bad;

    vecs[0] = '{0, 12'd2048, 1'b0, 4'd0, 128, 2048, 2032};
    vecs[1] = '{0, 12'd2048, 1'b0, 4'd3, 128, 2048, 1984};
    vecs[2] = '{1, 12'd2000, 1'b1, 4'd0,   8, 1000, 3000};
    vecs[3] = '{1, 12'd2000, 1'b0, 4'd0,  16, 3000, 1000};
    vecs[4] = '{0, 12'd2048, 1'b1, 4'd0, 256,    0, 4080};

    do_reset();
    check("reset_entry0", int'(disp[0]), 2047);
    check("reset_entries", count_not(12'd2047), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_triggered", int'(triggered), 0);

    foreach (vecs[v]) begin
      do_reset();
      fd_start     = fd_total;
      trig_level   = vecs[v].level;
      trig_falling = vecs[v].falling;
      decim        = vecs[v].decim;
      run          = 1'b1;
      tick(); tick();
      decim = 4'd7;  // must be ignored until the next arm
      stream(vecs[v].wave, 1500);
      check($sformatf("v%0d_early_pub", v), fd_total - fd_start, 0);
      run   = 1'b0;
      vblnk = 1'b1;
      tick();
      check($sformatf("v%0d_pub_latency", v), int'(frame_done), 1);
      vblnk = 1'b0;
      repeat (10) tick();
      check($sformatf("v%0d_frame_count", v), fd_total - fd_start, 1);
      check($sformatf("v%0d_entry0", v), int'(disp[0]), vecs[v].exp0);
      check($sformatf("v%0d_entry255", v), int'(disp[NS-1]), vecs[v].exp_last);
      bad = 0;
      for (int k = 0; k < NS; k++)
        if (disp[k] !== wave_val(vecs[v].wave, vecs[v].trig_i + k * (int'(vecs[v].decim) + 1))) bad++;
      check($sformatf("v%0d_all_entries", v), bad, 0);
      check($sformatf("v%0d_triggered", v), int'(triggered), 1);
    end

    // Completed frame held with no vblnk: display unchanged, later samples dropped.
    fd_start     = fd_total;
    trig_level   = 12'd2048;
    trig_falling = 1'b0;
    decim        = 4'd0;
    run          = 1'b1;
    tick(); tick();
    stream(0, 600);
    stream_const(12'd777, 1000);
    check("hold_no_pub", fd_total - fd_start, 0);
    check("hold_entry0", int'(disp[0]), 0);
    check("hold_entry255", int'(disp[NS-1]), 4080);
    run = 1'b0;
    pulse_vblnk();
    check("hold_pub_count", fd_total - fd_start, 1);
    check("hold_new_entry0", int'(disp[0]), 2048);
    check("hold_new_entry255", int'(disp[NS-1]), 2032);

    // Reset in the middle of a capture.
    do_reset();
    fd_start     = fd_total;
    trig_level   = 12'd2048;
    trig_falling = 1'b0;
    decim        = 4'd0;
    run          = 1'b1;
    tick(); tick();
    pulse_vblnk();
    stream(0, 229);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_entries", count_not(12'd2047), 0);
    check("midrst_triggered", int'(triggered), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    tick(); tick();
    pulse_vblnk();
    check("midrst_no_pub", fd_total - fd_start, 0);
    check("midrst_still_mid", int'(disp[5]), 2047);
    stream(0, 600);
    run = 1'b0;
    pulse_vblnk();
    check("midrst_rearm_pub", fd_total - fd_start, 1);
    check("midrst_rearm_entry0", int'(disp[0]), 2048);

    // Constant input below the level: only an auto-trigger can produce a frame.
    do_reset();
    fd_start     = fd_total;
    trig_level   = 12'd2000;
    trig_falling = 1'b0;
    decim        = 4'd0;
    run          = 1'b1;
    tick(); tick();
`ifdef CAPTURE_AUTO_TRIG_EN
    stream_const(12'd1500, 4096 + 255 - 1);
    pulse_vblnk();
    check("auto_not_yet", fd_total - fd_start, 0);
    stream_const(12'd1500, 1);
    run = 1'b0;
    pulse_vblnk();
    check("auto_pub", fd_total - fd_start, 1);
    check("auto_triggered", int'(triggered), 0);
    check("auto_entries", count_not(12'd1500), 0);
`else
    stream_const(12'd1500, 4400);
    run = 1'b0;
    pulse_vblnk();
    check("noauto_no_pub", fd_total - fd_start, 0);
    check("noauto_entries", count_not(12'd2047), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 256, number of samples per captured frame.
REQ-002 The block SHALL have parameter AUTO_TIMEOUT, default 4096, qualified samples to wait for a trigger before forcing one.
REQ-003 The block SHALL have port clk, input, 1, the single system clock.
REQ-004 The block SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port adc_data, input, 12, unsigned ADC sample (mid-scale 2047).
REQ-006 The block SHALL have port adc_valid, input, 1, adc_data qualifier, one-cycle strobe.
REQ-007 The block SHALL have port trig_level, input, 12, trigger threshold.
REQ-008 The block SHALL have port trig_falling, input, 1: 0 selects rising-edge trigger, 1 selects falling-edge trigger.
REQ-009 The block SHALL have port decim, input, 4, keep one of every decim+1 qualified samples.
REQ-010 The block SHALL have port run, input, 1: 1 re-arms after each publish, 0 freezes the display.
REQ-011 The block SHALL have port vblnk, input, 1, VGA vertical blank from the timing chain.
REQ-012 The block SHALL have port data_display, output, 12 x [0:N_SAMPLES-1], published frame for the display drawer.
REQ-013 The block SHALL have port frame_done, output, 1, one-cycle pulse on each publish.
REQ-014 The block SHALL have port triggered, output, 1: 1 = last publish came from a real trigger, 0 = it came from an auto-trigger.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_TRIG, CAPTURE, READY.
REQ-016 The decimator SHALL count qualified samples 0..decim; a sample is kept when the count is 0; decim=0 keeps every sample.
REQ-017 decim SHALL be latched on entry to WAIT_TRIG; changes mid-capture SHALL have no effect until the next arm.
REQ-018 A rising trigger SHALL be prev_kept < trig_level and cur_kept >= trig_level; a falling trigger SHALL be prev_kept >= trig_level and cur_kept < trig_level.
REQ-019 The first kept sample after arming SHALL only load prev_kept and SHALL never trigger.
REQ-020 In WAIT_TRIG, the triggering sample SHALL be written to back-buffer index 0, the write index SHALL be set to 1, and the FSM SHALL go to CAPTURE.
REQ-021 In CAPTURE, each kept sample SHALL be written at the write index, which then increments; after index N_SAMPLES-1 is written the FSM SHALL go to READY.
REQ-022 In READY, kept samples SHALL be dropped.
REQ-023 In READY, on a vblnk 0->1 edge (registered-previous compare), the back buffer SHALL be copied into data_display in one cycle and frame_done SHALL pulse.
REQ-024 After that publish, the FSM SHALL go to WAIT_TRIG if run=1, else to IDLE.
REQ-025 A vblnk rising edge in the same cycle CAPTURE writes the last sample SHALL not publish; publication SHALL wait for the next vblnk rising edge.
REQ-026 IDLE SHALL go to WAIT_TRIG when run=1.
REQ-027 data_display SHALL change only on the publish cycle.
REQ-028 Publication latency SHALL be 1 cycle: data_display and frame_done are valid on the cycle after the edge is seen.

Reset
REQ-029 Reset SHALL force: state IDLE; all counters 0; prev-valid flag cleared; frame_done 0; triggered 0.
REQ-030 Reset SHALL set every data_display entry and every back-buffer entry to 12'd2047, which draws a flat mid-scale trace.
REQ-031 Reset asserted mid-capture SHALL discard the partial frame; data_display SHALL not be published.

Configuration
REQ-032 With CAPTURE_AUTO_TRIG_EN defined, a timeout counter SHALL count kept samples in WAIT_TRIG.
REQ-033 With CAPTURE_AUTO_TRIG_EN defined, when the timeout counter reaches AUTO_TIMEOUT the current sample SHALL be treated as the trigger and the frame SHALL be marked triggered=0.
REQ-034 With CAPTURE_AUTO_TRIG_EN defined, the timeout counter SHALL clear on every entry to WAIT_TRIG.
REQ-035 Without CAPTURE_AUTO_TRIG_EN, WAIT_TRIG SHALL wait indefinitely, no timeout logic SHALL exist, and triggered SHALL be 1 after every publish.

Structure
REQ-036 N_SAMPLES default, ADC_MID (12'd2047) and the capture-state enum typedef SHALL live in vga_pkg.
REQ-037 Edge detection (prev register, level compare, polarity select) SHALL be a sub-module named trigger_detect.
REQ-038 The FSM, decimator, buffers and publish logic SHALL stay in sample_capture.

Verification
REQ-039 A bench SHALL cover this case: ramp 0..4095 step 16 every cycle, trig_level=2048, rising, decim=0, then a vblnk pulse. Required: data_display[0]=2048, [255]=6128 mod 4096=2032 (wrap), and one frame_done.
REQ-040 A bench SHALL cover this case: same ramp with decim=3. Required: data_display[k+1]-data_display[k]=64 (mod 4096).
REQ-041 A bench SHALL cover this case: falling trigger, square wave 3000/1000, trig_level=2000. Required: data_display[0]=1000.
REQ-042 A bench SHALL cover this case: capture completes with no vblnk for 1000 cycles. Required: data_display stays at its old value, and new samples are dropped.
REQ-043 A bench SHALL cover this case: constant input 1500, trig_level=2000, CAPTURE_AUTO_TRIG_EN defined. Required: publish after 4096+255 kept samples, triggered=0, all entries 1500.
REQ-044 A bench SHALL cover this case: without the macro, the same stimulus SHALL produce no publish.
REQ-045 A bench SHALL cover this case: rst at sample 100 of a capture. Required: all entries 2047, no frame_done, and after rst release with run=1 the block re-arms.
